// File: rtl/xor_frame_parity.sv
// Accumulates per-lane XOR parity of the two XOR-stage bits over FRAME_LEN beats,
// holds the frame result until consumed, and counts completed frames (saturating).
module xor_frame_parity #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_c,
  input  logic             in_d,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_par,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] LEN = 8'(FRAME_LEN);

  state_t           state_q, state_d;
  logic [1:0]       acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       par_q, par_d;
  logic             ovalid_q, ovalid_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]       beat;
  logic             accept;

  assign beat      = {in_d, in_c};
  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = ovalid_q;
  assign out_par   = par_q;
  assign frame_cnt = fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      par_q    <= '0;
      ovalid_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      ovalid_q <= ovalid_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    ovalid_d = ovalid_q;
    fcnt_d   = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_flush) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (LEN == 8'd1) begin
            par_d    = beat;
            ovalid_d = 1'b1;
            state_d  = HOLD;
          end else begin
            acc_d   = beat;
            cnt_d   = 8'd1;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_flush) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          // Final beat folds straight into the result register; acc restarts clean.
          if (cnt_q + 8'd1 == LEN) begin
            par_d    = acc_q ^ beat;
            ovalid_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = HOLD;
          end else begin
            acc_d = acc_q ^ beat;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
          if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Directed bench for xor_frame_parity: three instances cover the default frame,
// single-beat frames and a narrow saturating frame counter.
module tb_xor_frame_parity;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default instance: FRAME_LEN=8, CNT_W=8
  logic       a_vld = 0, a_c = 0, a_d = 0, a_fl = 0, a_ordy = 0;
  logic       a_rdy, a_ovld;
  logic [1:0] a_par;
  logic [7:0] a_cnt;

  // single-beat frames
  logic       b_vld = 0, b_c = 0, b_d = 0, b_fl = 0, b_ordy = 0;
  logic       b_rdy, b_ovld;
  logic [1:0] b_par;
  logic [7:0] b_cnt;

  // two-beat frames, 2-bit counter
  logic       s_vld = 0, s_c = 0, s_d = 0, s_fl = 0, s_ordy = 0;
  logic       s_rdy, s_ovld;
  logic [1:0] s_par;
  logic [1:0] s_cnt;

  xor_frame_parity #(.FRAME_LEN(8), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_rdy), .in_c(a_c), .in_d(a_d),
    .in_flush(a_fl), .out_valid(a_ovld), .out_ready(a_ordy), .out_par(a_par), .frame_cnt(a_cnt));

  xor_frame_parity #(.FRAME_LEN(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_ready(b_rdy), .in_c(b_c), .in_d(b_d),
    .in_flush(b_fl), .out_valid(b_ovld), .out_ready(b_ordy), .out_par(b_par), .frame_cnt(b_cnt));

  xor_frame_parity #(.FRAME_LEN(2), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s_rdy), .in_c(s_c), .in_d(s_d),
    .in_flush(s_fl), .out_valid(s_ovld), .out_ready(s_ordy), .out_par(s_par), .frame_cnt(s_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL rst_ovld got=%b exp=0", a_ovld); end
    n_cmp++; if (a_par !== 2'b00) begin n_err++; $display("FAIL rst_par got=%b exp=00", a_par); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy got=%b exp=1", a_rdy); end
    n_cmp++; if (b_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_b got=%b exp=1", b_rdy); end
  endtask

  task automatic test_frame();
    logic [7:0] cv;
    cv = 8'b0000_1101;  // beats c = 1,0,1,1,0,0,0,0 (bit i = beat i)
    for (int i = 0; i < 8; i++) begin
      a_vld = 1'b1; a_c = cv[i]; a_d = 1'b1;
      step();
      if (i == 6) begin
        n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL frame_early got=%b exp=0", a_ovld); end
      end
    end
    n_cmp++; if (a_ovld !== 1'b1) begin n_err++; $display("FAIL frame_ovld got=%b exp=1", a_ovld); end
    n_cmp++; if (a_par !== 2'b01) begin n_err++; $display("FAIL frame_par got=%b exp=01", a_par); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL frame_cnt0 got=%0d exp=0", a_cnt); end
  endtask

  task automatic test_hold();
    a_vld = 1'b1; a_c = 1'b1; a_d = 1'b1; a_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL hold_rdy[%0d] got=%b exp=0", i, a_rdy); end
      step();
      n_cmp++; if (a_ovld !== 1'b1 || a_par !== 2'b01)
        begin n_err++; $display("FAIL hold_out[%0d] got=%b/%b exp=1/01", i, a_ovld, a_par); end
    end
    a_vld = 1'b0; a_ordy = 1'b1;
    step();
    a_ordy = 1'b0;
    n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL cons_ovld got=%b exp=0", a_ovld); end
    n_cmp++; if (a_cnt !== 8'd1) begin n_err++; $display("FAIL cons_cnt got=%0d exp=1", a_cnt); end
    n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL cons_rdy got=%b exp=1", a_rdy); end
    n_cmp++; if (a_par !== 2'b01) begin n_err++; $display("FAIL cons_par_kept got=%b exp=01", a_par); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      a_vld = 1'b1; a_c = 1'b1; a_d = 1'b1;
      step();
    end
    a_fl = 1'b1; a_c = 1'b0; a_d = 1'b1;
    step();
    a_fl = 1'b0;
    n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL flush_ovld got=%b exp=0", a_ovld); end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin  // bubble with junk lane bits must be ignored
        a_vld = 1'b0; a_c = 1'b0; a_d = 1'b1;
        step();
      end
      a_vld = 1'b1; a_c = 1'b1; a_d = 1'b0;
      step();
      if (i == 6) begin
        n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL flush_early got=%b exp=0", a_ovld); end
      end
    end
    a_vld = 1'b0;
    n_cmp++; if (a_ovld !== 1'b1) begin n_err++; $display("FAIL flush_res got=%b exp=1", a_ovld); end
    n_cmp++; if (a_par !== 2'b00) begin n_err++; $display("FAIL flush_par got=%b exp=00", a_par); end
    a_ordy = 1'b1;
    step();
    a_ordy = 1'b0;
    n_cmp++; if (a_cnt !== 8'd2) begin n_err++; $display("FAIL flush_cnt got=%0d exp=2", a_cnt); end
    step();
    n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL flush_single got=%b exp=0", a_ovld); end
  endtask

  task automatic test_len1();
    b_vld = 1'b1; b_c = 1'b1; b_d = 1'b0;
    step();
    b_c = 1'b0; b_d = 1'b1;
    n_cmp++; if (b_ovld !== 1'b1) begin n_err++; $display("FAIL len1_ovld got=%b exp=1", b_ovld); end
    n_cmp++; if (b_par !== 2'b01) begin n_err++; $display("FAIL len1_par got=%b exp=01", b_par); end
    n_cmp++; if (b_rdy !== 1'b0) begin n_err++; $display("FAIL len1_rdy got=%b exp=0", b_rdy); end
    step();
    n_cmp++; if (b_rdy !== 1'b0 || b_par !== 2'b01)
      begin n_err++; $display("FAIL len1_held got=%b/%b exp=0/01", b_rdy, b_par); end
    b_vld = 1'b0; b_ordy = 1'b1;
    step();
    b_ordy = 1'b0;
    n_cmp++; if (b_ovld !== 1'b0 || b_cnt !== 8'd1)
      begin n_err++; $display("FAIL len1_cons got=%b/%0d exp=0/1", b_ovld, b_cnt); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int f = 0; f < 5; f++) begin
      s_vld = 1'b1; s_c = 1'b0; s_d = 1'b0;
      step();
      step();
      s_vld = 1'b0; s_ordy = 1'b1;
      step();
      s_ordy = 1'b0;
      n_cmp++; if (s_cnt !== exp_cnt[f])
        begin n_err++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", f, s_cnt, exp_cnt[f]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] cv, dv;
    for (int i = 0; i < 4; i++) begin
      a_vld = 1'b1; a_c = 1'b1; a_d = 1'b1;
      step();
    end
    a_c = 1'b0; a_d = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_cnt !== 8'd0 || a_ovld !== 1'b0)
      begin n_err++; $display("FAIL midrst got=%0d/%b exp=0/0", a_cnt, a_ovld); end
    step();
    rst_n = 1'b1;
    cv = 8'b1000_0011;  // c = 1,1,0,0,0,0,0,1
    dv = 8'b0000_0001;  // d = 1,0,0,0,0,0,0,0
    for (int i = 0; i < 8; i++) begin
      a_vld = 1'b1; a_c = cv[i]; a_d = dv[i];
      step();
      if (i < 7) begin
        n_cmp++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL midrst_spur[%0d] got=%b exp=0", i, a_ovld); end
      end
    end
    a_vld = 1'b0;
    n_cmp++; if (a_ovld !== 1'b1 || a_par !== 2'b11)
      begin n_err++; $display("FAIL midrst_res got=%b/%b exp=1/11", a_ovld, a_par); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_flush();
    test_len1();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xor_frame_parity.md
XOR_FRAME_PARITY -- requirements
Module: xor_frame_parity

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, beats per frame; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8, width of the frame counter output.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  the upstream XOR stage presents a beat.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port in_c  input  1  first XOR lane bit (output of the XOR2 submodule).
REQ-008 SHALL have port in_d  input  1  second XOR lane bit (output of the top-level XOR2).
REQ-009 SHALL have port in_flush  input  1  abort the current frame.
REQ-010 SHALL have port out_valid  output  1  frame result held.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-012 SHALL have port out_par  output  2  frame parity; [1]=XOR of all in_d beats, [0]=XOR of all in_c beats.
REQ-013 SHALL have port frame_cnt  output  CNT_W  count of completed frames, saturating.

Function
REQ-014 SHALL define a beat as accepted when in_valid and in_ready are both 1 at a rising clk edge.
REQ-015 SHALL implement states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD.
REQ-017 SHALL, in IDLE, on an accepted beat: load acc={in_d,in_c}, beat count=1, go to ACCUM; if FRAME_LEN==1, go directly to HOLD instead.
REQ-018 SHALL, in ACCUM, on an accepted beat: acc ^= {in_d,in_c}, increment the beat count.
REQ-019 SHALL close the frame on the beat that makes beat count equal FRAME_LEN: register out_par = acc ^ {in_d,in_c} and assert out_valid on the next cycle (1-cycle latency from the final beat), going to HOLD.
REQ-020 SHALL, in HOLD, keep out_par and out_valid stable until out_ready=1; on that edge clear out_valid, go to IDLE, and increment frame_cnt.
REQ-021 SHALL saturate frame_cnt at 2^CNT_W-1 with no wrap.
REQ-022 SHALL, when in_flush=1 in IDLE or ACCUM, discard acc and beat count, ignore any beat on that edge, and go to IDLE; frame_cnt and out_* remain unchanged.
REQ-023 SHALL ignore in_flush in HOLD, so that a held result is never lost.
REQ-024 SHALL drive out_par to its last registered value (not X) whenever out_valid=0.
REQ-025 SHALL leave acc and beat count unchanged when in_valid=0 in ACCUM, with no timeout.
REQ-026 SHALL treat in_c and in_d as don't-care when in_valid=0.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, acc=0, beat count=0, out_valid=0, out_par=2'b00, frame_cnt=0, and in_ready=1 once reset is released.
REQ-028 SHALL, on rst_n asserted mid-frame or in HOLD, drop any partial or held result without an out_valid pulse.
REQ-029 SHALL take first action on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: FRAME_LEN=8, beats c=1,0,1,1,0,0,0,0 and d all 1 with continuous valid -> out_valid one cycle after beat 8, out_par=2'b01, then frame_cnt=1 after out_ready.
REQ-031 SHALL cover: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_par stable, no beats accepted.
REQ-032 SHALL cover: in_flush on beat 4 of 8, then a fresh full frame of c=1 only -> a single result out_par=2'b00, frame_cnt increments by exactly 1.
REQ-033 SHALL cover: FRAME_LEN=1, beat c=1,d=0 -> out_valid the next cycle, out_par=2'b01, in_ready=0 until consumed.
REQ-034 SHALL cover: CNT_W=2 with 5 frames consumed -> frame_cnt reads 1,2,3,3,3.
REQ-035 SHALL cover: rst_n pulsed low on beat 5, then 8 new beats -> no spurious out_valid, and the result reflects only the post-reset beats.
